// File: rtl/mux_arb.sv
// -----------------------------------------------------------------------------
// mux_arb -- packet-level round-robin arbiter for a router output port.
//
// Locks the downstream 2:1 mux onto one input port from a HEAD flit through
// its TAIL flit, hands per-port grants back to the input stage, counts the
// flits of the current packet and raises a sticky flag on protocol errors.
//
// Ports:
//   clk       router clock, rising edge
//   rst_      asynchronous active-low reset
//   ivalid_0  port 0 has a flit          itype_0  flit type of port 0
//   ivalid_1  port 1 has a flit          itype_1  flit type of port 1
//   iready    downstream accepts a flit this cycle
//   sel       one-hot mux select (bit 0 = port 0, bit 1 = port 1, 0 = none)
//   grant_0   port 0 flit forwarded this cycle (combinational)
//   grant_1   port 1 flit forwarded this cycle (combinational)
//   busy      a packet is locked
//   flit_cnt  flits forwarded in the current/last packet, saturating
//   err       sticky protocol-error flag, cleared only by reset
//
// Handshake: a flit on the locked port moves when ivalid_x and iready are
// both high in the same cycle; grant_x reports exactly that transfer.
// -----------------------------------------------------------------------------
module mux_arb #(
  parameter int              PORT      = 4,
  parameter int              TYPEW     = 3,
  parameter int              CNTW      = 8,
  // Only HEAD and TAIL are decoded; every other type code counts as non-HEAD.
  parameter logic [TYPEW-1:0] TYPE_HEAD = TYPEW'(1),
  parameter logic [TYPEW-1:0] TYPE_TAIL = TYPEW'(3)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ivalid_0,
  input  logic [TYPEW-1:0] itype_0,
  input  logic             ivalid_1,
  input  logic [TYPEW-1:0] itype_1,
  input  logic             iready,
  output logic [PORT:0]    sel,
  output logic             grant_0,
  output logic             grant_1,
  output logic             busy,
  output logic [CNTW-1:0]  flit_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic [PORT:0]   SEL0    = (PORT+1)'(1);
  localparam logic [PORT:0]   SEL1    = (PORT+1)'(2);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  state_t           state;
  logic             last;      // port granted most recently
  logic             cand0;
  logic             cand1;
  logic             pick1;
  logic             fwd;
  logic [TYPEW-1:0] fwd_type;

  assign cand0 = ivalid_0 && (itype_0 == TYPE_HEAD);
  assign cand1 = ivalid_1 && (itype_1 == TYPE_HEAD);
  // Port 1 wins when it is the only candidate, or on a tie when port 0 was
  // the most recent winner.
  assign pick1 = cand1 && (!cand0 || !last);

  assign grant_0  = (state == LOCK0) && ivalid_0 && iready;
  assign grant_1  = (state == LOCK1) && ivalid_1 && iready;
  assign fwd      = grant_0 || grant_1;
  assign fwd_type = (state == LOCK1) ? itype_1 : itype_0;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      last     <= 1'b1;
      sel      <= '0;
      busy     <= 1'b0;
      flit_cnt <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Any valid flit that is not a HEAD has no packet to belong to.
          if ((ivalid_0 && !cand0) || (ivalid_1 && !cand1))
            err <= 1'b1;
          if (cand0 || cand1) begin
            state    <= pick1 ? LOCK1 : LOCK0;
            sel      <= pick1 ? SEL1 : SEL0;
            busy     <= 1'b1;
            flit_cnt <= '0;
            last     <= pick1;
          end
        end
        LOCK0, LOCK1: begin
          if (fwd) begin
            if (flit_cnt != CNT_MAX)
              flit_cnt <= flit_cnt + CNTW'(1);
            // The packet's own HEAD is always the first flit forwarded, which
            // is exactly when the counter is still 0; any later HEAD is bogus.
            if ((fwd_type == TYPE_HEAD) && (flit_cnt != '0))
              err <= 1'b1;
            if (fwd_type == TYPE_TAIL) begin
              state <= IDLE;
              sel   <= '0;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          sel   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arb.sv
// -----------------------------------------------------------------------------
// tb_mux_arb -- directed bench for mux_arb.
// Driver tasks apply one input vector per cycle (1 time unit after the rising
// edge) and push the hand-computed expected outputs for that cycle into
// exp_q. A separate monitor pops and compares on every falling edge, or
// immediately on sample_ev for asynchronous-reset checks.
// Expected vector layout: {sel[4:0], grant_0, grant_1, busy, flit_cnt[7:0], err}.
// -----------------------------------------------------------------------------
module tb_mux_arb;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_HEAD = 3'd1;
  localparam logic [2:0] T_DATA = 3'd2;
  localparam logic [2:0] T_TAIL = 3'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  logic       ivalid_0, ivalid_1, iready;
  logic [2:0] itype_0, itype_1;
  logic [4:0] sel;
  logic       grant_0, grant_1, busy, err;
  logic [7:0] flit_cnt;

  mux_arb #(.PORT(4), .TYPEW(3), .CNTW(8)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .ivalid_0 (ivalid_0),
    .itype_0  (itype_0),
    .ivalid_1 (ivalid_1),
    .itype_1  (itype_1),
    .iready   (iready),
    .sel      (sel),
    .grant_0  (grant_0),
    .grant_1  (grant_1),
    .busy     (busy),
    .flit_cnt (flit_cnt),
    .err      (err)
  );

  // scoreboard
  logic [16:0] exp_q[$];
  string       name_q[$];
  int          tests = 0;
  int          fails = 0;
  event        sample_ev;

  function automatic logic [16:0] pack(input logic [4:0] s, input logic g0,
                                       input logic g1, input logic b,
                                       input logic [7:0] c, input logic e);
    return {s, g0, g1, b, c, e};
  endfunction

  initial begin
    forever begin
      @(negedge clk or sample_ev);
      if (exp_q.size() > 0) begin
        logic [16:0] exp_v;
        logic [16:0] act_v;
        string       nm;
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act_v = pack(sel, grant_0, grant_1, busy, flit_cnt, err);
        tests++;
        if (act_v !== exp_v) begin
          fails++;
          $display("FAIL %s @%0t: got sel=%b g0=%b g1=%b busy=%b cnt=%0d err=%b, expected sel=%b g0=%b g1=%b busy=%b cnt=%0d err=%b",
                   nm, $time, act_v[16:12], act_v[11], act_v[10], act_v[9], act_v[8:1], act_v[0],
                   exp_v[16:12], exp_v[11], exp_v[10], exp_v[9], exp_v[8:1], exp_v[0]);
        end
      end
    end
  end

  // driver tasks
  task automatic step(input logic v0, input logic [2:0] t0,
                      input logic v1, input logic [2:0] t1, input logic rdy,
                      input logic [4:0] esel, input logic eg0, input logic eg1,
                      input logic ebusy, input logic [7:0] ecnt, input logic eerr,
                      input string nm);
    @(posedge clk);
    #1;
    ivalid_0 = v0; itype_0 = t0;
    ivalid_1 = v1; itype_1 = t1;
    iready   = rdy;
    exp_q.push_back(pack(esel, eg0, eg1, ebusy, ecnt, eerr));
    name_q.push_back(nm);
  endtask

  // Pulse reset between clock edges and check outputs before any edge.
  task automatic pulse_reset(input logic hold_v1, input string nm);
    @(posedge clk);
    #1;
    ivalid_0 = 1'b0; itype_0 = T_NONE;
    ivalid_1 = hold_v1; itype_1 = hold_v1 ? T_DATA : T_NONE;
    iready   = 1'b1;
    #1 rst_ = 1'b0;
    #1;
    exp_q.push_back(pack(5'b00000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0));
    name_q.push_back(nm);
    ->sample_ev;
    @(negedge clk);
    #1 rst_ = 1'b1;
    ivalid_1 = 1'b0; itype_1 = T_NONE;
  endtask

  initial begin
    rst_ = 1'b0;
    ivalid_0 = 1'b0; itype_0 = T_NONE;
    ivalid_1 = 1'b0; itype_1 = T_NONE;
    iready   = 1'b1;
    #3;
    exp_q.push_back(pack(5'b00000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0));
    name_q.push_back("reset_state");
    ->sample_ev;
    #19 rst_ = 1'b1;

    step(0, T_NONE, 0, T_NONE, 1, 5'b00000, 0, 0, 0, 8'd0, 0, "idle_after_reset");

    // Tie and rotation: port 0 first, then port 1, then port 0 again.
    step(1, T_HEAD, 1, T_HEAD, 1, 5'b00000, 0, 0, 0, 8'd0, 0, "tie_arb");
    step(1, T_HEAD, 1, T_HEAD, 1, 5'b00001, 1, 0, 1, 8'd0, 0, "tie_lock0_head");
    step(1, T_TAIL, 1, T_HEAD, 1, 5'b00001, 1, 0, 1, 8'd1, 0, "tie_lock0_tail");
    step(1, T_HEAD, 1, T_HEAD, 1, 5'b00000, 0, 0, 0, 8'd2, 0, "tie_release0");
    step(1, T_HEAD, 1, T_HEAD, 1, 5'b00010, 0, 1, 1, 8'd0, 0, "rot_lock1_head");
    step(1, T_HEAD, 1, T_TAIL, 1, 5'b00010, 0, 1, 1, 8'd1, 0, "rot_lock1_tail");
    step(1, T_HEAD, 0, T_NONE, 1, 5'b00000, 0, 0, 0, 8'd2, 0, "rot_release1");
    step(1, T_HEAD, 0, T_NONE, 1, 5'b00001, 1, 0, 1, 8'd0, 0, "rot_lock0_head");
    step(1, T_TAIL, 0, T_NONE, 1, 5'b00001, 1, 0, 1, 8'd1, 0, "rot_lock0_tail");
    step(0, T_NONE, 0, T_NONE, 1, 5'b00000, 0, 0, 0, 8'd2, 0, "rot_release0");

    // Single packet on port 1: HEAD, 20 x DATA, TAIL.
    step(0, T_NONE, 1, T_HEAD, 1, 5'b00000, 0, 0, 0, 8'd2, 0, "single_arb");
    step(0, T_NONE, 1, T_HEAD, 1, 5'b00010, 0, 1, 1, 8'd0, 0, "single_head");
    for (int i = 1; i <= 20; i++)
      step(0, T_NONE, 1, T_DATA, 1, 5'b00010, 0, 1, 1, 8'(i), 0, "single_data");
    step(0, T_NONE, 1, T_TAIL, 1, 5'b00010, 0, 1, 1, 8'd21, 0, "single_tail");
    step(0, T_NONE, 0, T_NONE, 1, 5'b00000, 0, 0, 0, 8'd22, 0, "single_release");

    // Backpressure on port 0 for 3 cycles mid-packet.
    step(1, T_HEAD, 0, T_NONE, 1, 5'b00000, 0, 0, 0, 8'd22, 0, "bp_arb");
    step(1, T_HEAD, 0, T_NONE, 1, 5'b00001, 1, 0, 1, 8'd0, 0, "bp_head");
    step(1, T_DATA, 0, T_NONE, 1, 5'b00001, 1, 0, 1, 8'd1, 0, "bp_data1");
    step(1, T_DATA, 0, T_NONE, 1, 5'b00001, 1, 0, 1, 8'd2, 0, "bp_data2");
    for (int i = 0; i < 3; i++)
      step(1, T_DATA, 0, T_NONE, 0, 5'b00001, 0, 0, 1, 8'd3, 0, "bp_stall");
    step(1, T_DATA, 0, T_NONE, 1, 5'b00001, 1, 0, 1, 8'd3, 0, "bp_resume");
    step(1, T_TAIL, 0, T_NONE, 1, 5'b00001, 1, 0, 1, 8'd4, 0, "bp_tail");
    step(0, T_NONE, 0, T_NONE, 1, 5'b00000, 0, 0, 0, 8'd5, 0, "bp_release");

    // DATA while idle: no grant, sticky err.
    step(1, T_DATA, 0, T_NONE, 1, 5'b00000, 0, 0, 0, 8'd5, 0, "err_idle_data");
    step(0, T_NONE, 0, T_NONE, 1, 5'b00000, 0, 0, 0, 8'd5, 1, "err_idle_set");
    step(0, T_NONE, 0, T_NONE, 1, 5'b00000, 0, 0, 0, 8'd5, 1, "err_sticky");
    pulse_reset(1'b0, "err_cleared_by_reset");

    // Second HEAD inside a locked packet.
    step(1, T_HEAD, 0, T_NONE, 1, 5'b00000, 0, 0, 0, 8'd0, 0, "dup_arb");
    step(1, T_HEAD, 0, T_NONE, 1, 5'b00001, 1, 0, 1, 8'd0, 0, "dup_head");
    step(1, T_DATA, 0, T_NONE, 1, 5'b00001, 1, 0, 1, 8'd1, 0, "dup_data");
    step(1, T_HEAD, 1, T_DATA, 1, 5'b00001, 1, 0, 1, 8'd2, 0, "dup_head2");
    step(1, T_DATA, 1, T_DATA, 1, 5'b00001, 1, 0, 1, 8'd3, 1, "dup_err_lock_held");
    step(1, T_TAIL, 0, T_NONE, 1, 5'b00001, 1, 0, 1, 8'd4, 1, "dup_tail");
    step(0, T_NONE, 0, T_NONE, 1, 5'b00000, 0, 0, 0, 8'd5, 1, "dup_release");

    // Reset mid-packet on port 1 after 5 DATA flits.
    pulse_reset(1'b0, "pre_midreset");
    step(0, T_NONE, 1, T_HEAD, 1, 5'b00000, 0, 0, 0, 8'd0, 0, "mid_arb");
    step(0, T_NONE, 1, T_HEAD, 1, 5'b00010, 0, 1, 1, 8'd0, 0, "mid_head");
    for (int i = 1; i <= 5; i++)
      step(0, T_NONE, 1, T_DATA, 1, 5'b00010, 0, 1, 1, 8'(i), 0, "mid_data");
    pulse_reset(1'b1, "mid_async_reset");
    step(0, T_NONE, 1, T_HEAD, 1, 5'b00000, 0, 0, 0, 8'd0, 0, "fresh_arb");
    step(0, T_NONE, 1, T_HEAD, 1, 5'b00010, 0, 1, 1, 8'd0, 0, "fresh_head");
    step(0, T_NONE, 1, T_TAIL, 1, 5'b00010, 0, 1, 1, 8'd1, 0, "fresh_tail");
    step(0, T_NONE, 0, T_NONE, 1, 5'b00000, 0, 0, 0, 8'd2, 0, "fresh_release");

    // 300-flit packet on port 0: counter saturates at 255, TAIL still releases.
    step(1, T_HEAD, 0, T_NONE, 1, 5'b00000, 0, 0, 0, 8'd2, 0, "sat_arb");
    step(1, T_HEAD, 0, T_NONE, 1, 5'b00001, 1, 0, 1, 8'd0, 0, "sat_head");
    for (int i = 1; i <= 298; i++)
      step(1, T_DATA, 0, T_NONE, 1, 5'b00001, 1, 0, 1, (i > 255) ? 8'd255 : 8'(i), 0, "sat_data");
    step(1, T_TAIL, 0, T_NONE, 1, 5'b00001, 1, 0, 1, 8'd255, 0, "sat_tail");
    step(0, T_NONE, 0, T_NONE, 1, 5'b00000, 0, 0, 0, 8'd255, 0, "sat_release");

    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
